// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty,
// FWFT or registered-read output, synchronous flush and sticky error flags.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wrt_en,
  input  logic [DATA_WIDTH-1:0] data_wrt,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = PW'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = PW'(1);

  if (DEPTH != (1 << ADDR_WIDTH) || !(0 < AEMPTY_THRESH && AEMPTY_THRESH < AFULL_THRESH
      && AFULL_THRESH < DEPTH)) begin : g_param_err
    $error("sync_fifo_ctrl: illegal DEPTH/ADDR_WIDTH/threshold combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wrt_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   wrt_ptr_nxt, rd_ptr_nxt;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;

  // Level flags decode only from the registered count.
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wrt_en && !full && !clr;
  assign rd_acc = rd_en && !empty && !clr;

  always_comb begin
    wrt_ptr_nxt = wrt_ptr;
    rd_ptr_nxt  = rd_ptr;
    if (clr) begin
      wrt_ptr_nxt = '0;
      rd_ptr_nxt  = '0;
    end else begin
      if (wr_acc) wrt_ptr_nxt = wrt_ptr + PTR_ONE;
      if (rd_acc) rd_ptr_nxt  = rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_ptr     <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrt_ptr <= wrt_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      // Wrap bit makes the modulo difference the true fill level 0..DEPTH.
      count_q <= wrt_ptr_nxt - rd_ptr_nxt;
      if (clr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (wrt_en && full) overflow_q  <= 1'b1;
        if (rd_en && empty) underflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wrt_ptr[ADDR_WIDTH-1:0]] <= data_wrt;
  end

  if (FWFT) begin : g_fwft
    // Masked while empty so the output reads zero out of reset.
    assign data_rd  = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign rd_valid = !empty;
  end else begin : g_reg_rd
    logic [DATA_WIDTH-1:0] data_rd_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_rd_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) data_rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end

    assign data_rd  = data_rd_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: FWFT and registered-read instances share stimulus
// and are checked against a queue-based reference model.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, wrt_en, rd_en;
  logic [7:0] data_wrt;

  logic       full1, afull1, empty1, aempty1, rv1, ovf1, unf1;
  logic [7:0] drd1;
  logic [4:0] cnt1;
  logic       full0, afull0, empty0, aempty0, rv0, ovf0, unf0;
  logic [7:0] drd0;
  logic [4:0] cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rv0;
  logic [7:0] m_last0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.FWFT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wrt_en(wrt_en), .data_wrt(data_wrt),
    .full(full1), .almost_full(afull1), .rd_en(rd_en), .data_rd(drd1),
    .rd_valid(rv1), .empty(empty1), .almost_empty(aempty1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1));

  sync_fifo_ctrl #(.FWFT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wrt_en(wrt_en), .data_wrt(data_wrt),
    .full(full0), .almost_full(afull0), .rd_en(rd_en), .data_rd(drd0),
    .rd_valid(rv0), .empty(empty0), .almost_empty(aempty0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    check("count1",  32'(cnt1),   32'(n));
    check("count0",  32'(cnt0),   32'(n));
    check("full",    32'(full1),  32'(n == 16));
    check("afull",   32'(afull1), 32'(n >= 14));
    check("empty",   32'(empty1), 32'(n == 0));
    check("aempty",  32'(aempty1),32'(n <= 2));
    check("ovf",     32'(ovf1),   32'(m_ovf));
    check("unf",     32'(unf1),   32'(m_unf));
    check("flags0",  32'({full0, afull0, empty0, aempty0, ovf0, unf0}),
                     32'({n == 16, n >= 14, n == 0, n <= 2, m_ovf, m_unf}));
    check("rv_fwft", 32'(rv1),    32'(n != 0));
    if (n != 0) check("data_fwft", 32'(drd1), 32'(q[0]));
    check("rv_reg",   32'(rv0),   32'(m_rv0));
    check("data_reg", 32'(drd0),  32'(m_last0));
  endtask

  // Drive one cycle of requests (called just after a negedge), then check.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit m_full, m_empty, wa, ra;
    wrt_en = w; data_wrt = d; rd_en = r; clr = c;
    m_full  = (q.size() == 16);
    m_empty = (q.size() == 0);
    wa = w && !m_full && !c;
    ra = r && !m_empty && !c;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv0 = 0;
    end else begin
      if (w && m_full)  m_ovf = 1;
      if (r && m_empty) m_unf = 1;
      m_rv0 = ra;
      if (ra) m_last0 = q.pop_front();
      if (wa) q.push_back(d);
    end
    @(negedge clk);
    wrt_en = 0; rd_en = 0; clr = 0;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; clr = 0; wrt_en = 0; rd_en = 0; data_wrt = '0;
    m_ovf = 0; m_unf = 0; m_rv0 = 0; m_last0 = '0;
    #3;
    check_all();
    check("rst_data0", 32'(drd0), 32'h0);
    check("rst_data1", 32'(drd1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
    check("filled", 32'(full1), 32'h1);

    cycle(1, 8'hAA, 0, 0);
    check("ovf_set", 32'(ovf1), 32'h1);
    cycle(0, 8'h00, 0, 0);

    for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0);
    check("drained", 32'(empty1), 32'h1);

    cycle(1, 8'h55, 1, 0);
    check("unf_set", 32'(unf1), 32'h1);
    check("head55",  32'(drd1), 32'h55);

    for (int i = 0; i < 7; i++) cycle(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 8'($urandom), 1, 0);
    check("steady8", 32'(cnt1), 32'd8);

    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check("lat_data", 32'(drd0), 32'h11);
    check("lat_rv",   32'(rv0),  32'h1);
    cycle(0, 8'h00, 0, 0);
    check("lat_rv_off", 32'(rv0), 32'h0);

    while (q.size() < 16) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'hAA, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 8'h00, 1, 0);
    check("pre_flush", 32'(cnt1), 32'd9);
    cycle(1, 8'h99, 0, 1);
    check("flush_cnt", 32'(cnt1), 32'd0);
    check("flush_ovf", 32'(ovf1), 32'h0);

    for (int seg = 0; seg < 6; seg++) begin
      int pw = (seg % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 60; i++)
        cycle(($urandom_range(0, 99) < pw), 8'($urandom),
              ($urandom_range(0, 99) >= pw), ($urandom_range(0, 63) == 0));
    end

    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 0, 0);
    wrt_en = 1; rd_en = 1; data_wrt = 8'h3C;
    #2 rst_n = 1'b0;
    #1;
    q.delete(); m_ovf = 0; m_unf = 0; m_rv0 = 0; m_last0 = '0;
    check_all();
    check("async_cnt", 32'(cnt0), 32'd0);
    #1 rst_n = 1'b1;
    cycle(1, 8'h77, 0, 0);
    check("post_rst_cnt",  32'(cnt1), 32'd1);
    check("post_rst_head", 32'(drd1), 32'h77);
    cycle(0, 8'h00, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
